// File: rtl/prbs_pkg.sv
// Shared types, level constants and arithmetic widths for the PRBS edge shaper.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RAMP = 2'd2
  } state_t;

  localparam int LEVEL_W     = 16;
  localparam int S_W         = 17;
  localparam int PROD_W      = 33;
  localparam int P_W         = 17;
  localparam int SUM_W       = 18;
  localparam int PIPE_STAGES = 2;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 16'd65534;
  localparam logic [LEVEL_W-1:0] LEVEL_MID = 16'd32767;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -18'sd32768;
  localparam logic [15:0] OUT_MAX = 16'h7FFF;
  localparam logic [15:0] OUT_MIN = 16'h8000;

  function automatic logic [LEVEL_W-1:0] level_target(input logic b);
    return b ? LEVEL_MAX : '0;
  endfunction

  // One ramp step toward tgt; lands exactly on tgt once the gap fits in stp.
  function automatic logic [LEVEL_W-1:0] ramp_next(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [LEVEL_W-1:0] tgt,
                                                   input logic [LEVEL_W-1:0] stp);
    logic [LEVEL_W-1:0] r;
    if (tgt >= lvl) r = ((tgt - lvl) <= stp) ? tgt : lvl + stp;
    else            r = ((lvl - tgt) <= stp) ? tgt : lvl - stp;
    return r;
  endfunction

endpackage

// File: rtl/prbs_edge_step_rom.sv
// Step-size table: step[E] = ceil(65534/E), entries 0 and 1 give a full-swing step.
module prbs_edge_step_rom
  import prbs_pkg::*;
(
  input  logic [7:0]         edge_time,
  output logic [LEVEL_W-1:0] step
);

  function automatic logic [LEVEL_W-1:0] step_entry(input int e);
    if (e <= 1) return LEVEL_MAX;
    return LEVEL_W'((int'(LEVEL_MAX) + e - 1) / e);
  endfunction

  logic [LEVEL_W-1:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = step_entry(i);
  end

  assign step = rom[edge_time];

endmodule

// File: rtl/prbs_edge_shaper.sv
// Turns the serial PRBS bit stream into ramp-shaped, gained, offset 16-bit DAC samples.
module prbs_edge_shaper
  import prbs_pkg::*;
(
  input  logic        dac_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        bit_in,
  input  logic        bit_strobe,
  input  logic [7:0]  edge_time_config,
  input  logic [15:0] amplitude_config,
  input  logic [15:0] dc_offset_config,
  output logic [15:0] dac_data,
  output logic        dac_valid,
  output logic        ramp_active
);

  state_t             state;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] target;
  logic [LEVEL_W-1:0] step;

  logic [LEVEL_W-1:0] rom_step;
  logic [LEVEL_W-1:0] bit_target;
  logic [LEVEL_W-1:0] ramp_tgt;
  logic [LEVEL_W-1:0] ramp_step;
  logic [LEVEL_W-1:0] ramp_level;
  logic               hard_step;

  prbs_edge_step_rom u_step_rom (
    .edge_time (edge_time_config),
    .step      (rom_step)
  );

  // A strobe during RAMP retargets and relatches the step in the same cycle,
  // so the level reverses from where it is without a stall or a snap.
  always_comb begin
    bit_target = level_target(bit_in);
    hard_step  = (edge_time_config <= 8'd1);
    ramp_tgt   = bit_strobe ? bit_target : target;
    ramp_step  = (bit_strobe && (bit_target != target)) ? rom_step : step;
    ramp_level = ramp_next(level, ramp_tgt, ramp_step);
  end

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      level  <= '0;
      target <= '0;
      step   <= '0;
    end else if (!enable) begin
      state  <= ST_IDLE;
      level  <= '0;
      target <= '0;
      step   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bit_strobe) begin
            state  <= ST_HOLD;
            level  <= bit_target;
            target <= bit_target;
          end
        end
        ST_HOLD: begin
          if (bit_strobe && (bit_target != level)) begin
            target <= bit_target;
            if (hard_step) begin
              level <= bit_target;
            end else begin
              step  <= rom_step;
              state <= ST_RAMP;
            end
          end
        end
        ST_RAMP: begin
          target <= ramp_tgt;
          step   <= ramp_step;
          level  <= ramp_level;
          if (ramp_level == ramp_tgt) state <= ST_HOLD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ramp_active = (state == ST_RAMP);

  logic signed [S_W-1:0]    s;
  logic signed [PROD_W-1:0] s_wide;
  logic signed [PROD_W-1:0] amp_wide;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [P_W-1:0]    p;
  logic signed [SUM_W-1:0]  sum;
  logic [15:0]              sat;
  logic signed [P_W-1:0]    prod_q;
  logic                     valid_d1;

  // Product stage uses the live gain, output stage the live offset.
  always_comb begin
    s         = $signed({1'b0, level}) - $signed({1'b0, LEVEL_MID});
    s_wide    = {{(PROD_W-S_W){s[S_W-1]}}, s};
    amp_wide  = {{(PROD_W-16){1'b0}}, amplitude_config};
    prod_full = s_wide * amp_wide;
    p         = P_W'(prod_full >>> 16);
    sum       = $signed({prod_q[P_W-1], prod_q})
              + $signed({{(SUM_W-16){dc_offset_config[15]}}, dc_offset_config});
    if (sum > SAT_MAX)      sat = OUT_MAX;
    else if (sum < SAT_MIN) sat = OUT_MIN;
    else                    sat = sum[15:0];
  end

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      valid_d1  <= 1'b0;
      prod_q    <= '0;
      dac_valid <= 1'b0;
      dac_data  <= '0;
    end else begin
      valid_d1  <= (state != ST_IDLE);
      prod_q    <= p;
      dac_valid <= valid_d1;
      dac_data  <= valid_d1 ? sat : 16'h0000;
    end
  end

endmodule

// File: tb/tb_prbs_edge_shaper.sv
// Directed bench for prbs_edge_shaper: vector table plus ramp, retarget and disable sequences.
module tb_prbs_edge_shaper;

  logic        dac_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_strobe = 1'b0;
  logic [7:0]  edge_time_config = 8'd0;
  logic [15:0] amplitude_config = 16'h0000;
  logic [15:0] dc_offset_config = 16'h0000;
  logic [15:0] dac_data;
  logic        dac_valid;
  logic        ramp_active;

  prbs_edge_shaper dut (
    .dac_clk          (dac_clk),
    .reset            (reset),
    .enable           (enable),
    .bit_in           (bit_in),
    .bit_strobe       (bit_strobe),
    .edge_time_config (edge_time_config),
    .amplitude_config (amplitude_config),
    .dc_offset_config (dc_offset_config),
    .dac_data         (dac_data),
    .dac_valid        (dac_valid),
    .ramp_active      (ramp_active)
  );

  always #5 dac_clk = ~dac_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  localparam int TR_N = 4096;
  logic [15:0] dac_tr [TR_N];
  logic        va_tr  [TR_N];
  logic        ra_tr  [TR_N];
  logic [15:0] exp_q [$];

  typedef struct {
    logic        b;
    logic [7:0]  e;
    logic [15:0] amp;
    logic [15:0] off;
    logic [15:0] exp_dac;
  } vec_t;
  vec_t vecs [11];

  task automatic tick();
    @(posedge dac_clk);
    #1;
    cyc++;
    if (cyc < TR_N) begin
      dac_tr[cyc] = dac_data;
      va_tr[cyc]  = dac_valid;
      ra_tr[cyc]  = ramp_active;
    end
  endtask

  task automatic strobe(input logic b);
    bit_in     = b;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ra_count(input int from, input int to);
    int n = 0;
    for (int k = from; k <= to; k++) if (ra_tr[k]) n++;
    return n;
  endfunction

  initial begin
    int base;

    vecs[0]  = '{1'b1, 8'd0, 16'hFFFF, 16'h0000, 16'h7FFE};
    vecs[1]  = '{1'b0, 8'd0, 16'hFFFF, 16'h0000, 16'h8001};
    vecs[2]  = '{1'b1, 8'd1, 16'hFFFF, 16'h0000, 16'h7FFE};
    vecs[3]  = '{1'b1, 8'd0, 16'hFFFF, 16'h7000, 16'h7FFF};
    vecs[4]  = '{1'b0, 8'd1, 16'hFFFF, 16'h9000, 16'h8000};
    vecs[5]  = '{1'b1, 8'd0, 16'h8000, 16'h0000, 16'h3FFF};
    vecs[6]  = '{1'b0, 8'd0, 16'h8000, 16'h0000, 16'hC000};
    vecs[7]  = '{1'b1, 8'd0, 16'h0000, 16'h1234, 16'h1234};
    vecs[8]  = '{1'b1, 8'd0, 16'hFFFF, 16'hFFFF, 16'h7FFD};
    vecs[9]  = '{1'b0, 8'd0, 16'h0000, 16'h8000, 16'h8000};
    vecs[10] = '{1'b0, 8'd0, 16'hFFFF, 16'h0100, 16'h8101};

    // Reset, then strobes while disabled must leave the output silent.
    repeat (5) tick();
    chk16("reset_dac", dac_data, 16'h0000);
    chk1("reset_valid", dac_valid, 1'b0);
    chk1("reset_ramp", ramp_active, 1'b0);
    reset = 1'b0;
    base = cyc;
    strobe(1'b1);
    tick();
    strobe(1'b0);
    repeat (3) tick();
    for (int k = base + 1; k <= cyc; k++) begin
      chk16($sformatf("idle_dac[%0d]", k - base), dac_tr[k], 16'h0000);
      chk1($sformatf("idle_valid[%0d]", k - base), va_tr[k], 1'b0);
    end

    // Hard steps, gain and saturation vectors.
    enable = 1'b1;
    foreach (vecs[i]) begin
      edge_time_config = vecs[i].e;
      amplitude_config = vecs[i].amp;
      dc_offset_config = vecs[i].off;
      strobe(vecs[i].b);
      base = cyc;
      repeat (3) tick();
      chk16($sformatf("vec%0d_dac", i), dac_data, vecs[i].exp_dac);
      chk1($sformatf("vec%0d_valid", i), dac_valid, 1'b1);
      chkint($sformatf("vec%0d_ramp", i), ra_count(base, cyc), 0);
    end

    // Full-swing ramp with E=4 from level 0.
    edge_time_config = 8'd4;
    amplitude_config = 16'hFFFF;
    dc_offset_config = 16'h0000;
    strobe(1'b1);
    base = cyc;
    repeat (10) tick();
    chk16("ramp4_start", dac_tr[base + 2], 16'h8001);
    exp_q.push_back(16'(-16383));
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd16384);
    exp_q.push_back(16'd32766);
    for (int k = 0; k < 4; k++)
      chk16($sformatf("ramp4[%0d]", k), dac_tr[base + 3 + k], exp_q.pop_front());
    chkint("ramp4_active_cycles", ra_count(base, base + 9), 4);

    // Back to 0, then E=8 ramp retargeted at level 24576.
    edge_time_config = 8'd0;
    strobe(1'b0);
    repeat (3) tick();
    edge_time_config = 8'd8;
    strobe(1'b1);
    base = cyc;
    repeat (3) tick();
    strobe(1'b0);
    repeat (5) tick();
    exp_q.push_back(16'(-32767));
    exp_q.push_back(16'(-24575));
    exp_q.push_back(16'(-16383));
    exp_q.push_back(16'(-8191));
    exp_q.push_back(16'(-16383));
    exp_q.push_back(16'(-24575));
    exp_q.push_back(16'(-32767));
    for (int k = 0; k < 7; k++)
      chk16($sformatf("retarget[%0d]", k), dac_tr[base + 2 + k], exp_q.pop_front());
    chkint("retarget_active_cycles", ra_count(base, base + 5), 6);
    chk1("retarget_done", ra_tr[base + 6], 1'b0);

    // E=100 ramp, enable dropped at ramp cycle 10, then re-enabled.
    edge_time_config = 8'd100;
    strobe(1'b1);
    base = cyc;
    repeat (9) tick();
    enable = 1'b0;
    repeat (4) tick();
    chk1("dis_ramp_before", ra_tr[base + 9], 1'b1);
    chk1("dis_ramp_after", ra_tr[base + 10], 1'b0);
    chk1("dis_valid_lag", va_tr[base + 11], 1'b1);
    chk16("dis_last_sample", dac_tr[base + 11], 16'(-26863));
    chk1("dis_valid_low", va_tr[base + 12], 1'b0);
    chk16("dis_dac_zero", dac_tr[base + 12], 16'h0000);
    enable = 1'b1;
    strobe(1'b1);
    base = cyc;
    repeat (3) tick();
    chk16("reen_first", dac_tr[base + 2], 16'h7FFE);
    chk16("reen_dac", dac_tr[base + 3], 16'h7FFE);
    chk1("reen_valid", va_tr[base + 3], 1'b1);
    chkint("reen_ramp", ra_count(base, base + 3), 0);

    // Strobe coinciding with enable falling: disable wins.
    enable = 1'b0;
    strobe(1'b0);
    base = cyc;
    repeat (3) tick();
    chk1("coinc_ramp", ra_tr[base], 1'b0);
    chk1("coinc_valid", va_tr[base + 2], 1'b0);
    chk16("coinc_dac", dac_tr[base + 2], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
